mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for multiply-class ops.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for divide-class ops.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 SHALL have port op  input  4  operation code (package encoding).
REQ-007 SHALL have port src_a  input  32  forwarded rs operand from E stage.
REQ-008 SHALL have port src_b  input  32  forwarded rt operand from E stage.
REQ-009 SHALL have port busy  output  1  operation in flight; hazard unit stalls MDU-type D instructions on busy|start.
REQ-010 SHALL have port hi  output  32  HI register, read by mfhi.
REQ-011 SHALL have port lo  output  32  LO register, read by mflo.

Function
REQ-012 SHALL use two states, IDLE and BUSY; busy = 1 exactly in BUSY.
REQ-013 IDLE, start=1, op in {MULT, MULTU}: SHALL latch operands and result, load counter with MULT_CYCLES, enter BUSY next edge.
REQ-014 IDLE, start=1, op in {DIV, DIVU}: same as REQ-013 with DIV_CYCLES.
REQ-015 BUSY: counter SHALL decrement each cycle; on the edge where it reaches 0, hi/lo SHALL commit and state SHALL return to IDLE at that same edge.
REQ-016 busy SHALL stay high for exactly N consecutive cycles after the start cycle (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 hi/lo SHALL keep their old values throughout BUSY.
REQ-018 MULT: signed 32x32->64; hi = product[63:32], lo = product[31:0]. MULTU: same, unsigned.
REQ-019 DIV: signed; lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-021 DIVU: unsigned quotient to lo, remainder to hi.
REQ-022 Divisor 0 (DIV or DIVU): SHALL still run DIV_CYCLES busy cycles; hi/lo unchanged at commit.
REQ-023 MTHI/MTLO with start=1 in IDLE: SHALL write src_a to hi/lo at next edge; busy stays 0.
REQ-024 start=1 while BUSY SHALL be ignored for all ops; this condition is a stall failure upstream.
REQ-025 op = NONE or an undefined code with start=1 SHALL have no effect.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, counter 0, busy 0, hi 0, lo 0, and discard any in-flight result, including mid-BUSY.
REQ-027 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-028 Macro MDU_MADD_EN defined: SHALL accept MADD, MADDU, MSUB, MSUBU with MULT_CYCLES latency; {hi,lo} +/- signed or unsigned 64-bit product, modulo 2^64, with hi/lo sampled at start.
REQ-029 MDU_MADD_EN undefined: these four codes SHALL be treated as undefined per REQ-025; no accumulate adder SHALL be synthesized.

Structure
REQ-030 Shared package mdu_pkg SHALL hold the op encoding constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10) and the default cycle counts.
REQ-031 The result computation SHALL be one combinational sub-module, mdu_calc (op, src_a, src_b, hi, lo -> next_hi, next_lo); state, counter and registers SHALL live in mul_div_unit.

Verification
REQ-032 MULT src_a=0xFFFFFFFD, src_b=7 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 MULTU src_a=0xFFFFFFFF, src_b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 hi=0x11, lo=0x22, then DIVU src_b=0 -> busy for 10 cycles, then hi=0x11, lo=0x22; a second start and an MTHI during BUSY -> both ignored.
REQ-036 reset on the 3rd busy cycle of a MULT -> next cycle busy=0, hi=0, lo=0, and no later commit.
REQ-037 MDU_MADD_EN defined, hi=0, lo=5, MADD src_a=2, src_b=3 -> after 5 cycles lo=11, hi=0; undefined build -> hi/lo unchanged, busy never rises.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encoding, default latencies, FSM state type and
// op-class helpers for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract ops).
package mdu_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUB  = 4'd9;
  localparam logic [3:0] MSUBU = 4'd10;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Multiply-class ops run for MULT_CYCLES; accumulate ops only when enabled.
  function automatic logic op_is_mul(input logic [3:0] op);
    logic r;
    r = (op == MULT) || (op == MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
    return r;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_move(input logic [3:0] op);
    return (op == MTHI) || (op == MTLO);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational HI/LO result for every MDU op.
// Ops that do not touch HI/LO (including divide by zero) return hi/lo as-is.
// Optional feature macro: MDU_MADD_EN adds the 64-bit accumulate adder.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        div_zero;

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 rem 0 without relying on tool overflow behaviour.
  always_comb begin
    prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u   = {32'd0, src_a} * {32'd0, src_b};
    div_zero = (src_b == 32'd0);
    mag_a    = src_a[31] ? (32'd0 - src_a) : src_a;
    mag_b    = src_b[31] ? (32'd0 - src_b) : src_b;
    sq       = div_zero ? 32'd0 : (mag_a / mag_b);
    sr       = div_zero ? 32'd0 : (mag_a % mag_b);
    uq       = div_zero ? 32'd0 : (src_a / src_b);
    ur       = div_zero ? 32'd0 : (src_a % src_b);
  end

  // Select the result for the current op; default keeps HI/LO unchanged.
  always_comb begin
    next_hi = hi;
    next_lo = lo;
    case (op)
      MULT:  {next_hi, next_lo} = prod_s;
      MULTU: {next_hi, next_lo} = prod_u;
      DIV: begin
        if (!div_zero) begin
          next_lo = (src_a[31] ^ src_b[31]) ? (32'd0 - sq) : sq;
          next_hi = src_a[31] ? (32'd0 - sr) : sr;
        end
      end
      DIVU: begin
        if (!div_zero) begin
          next_lo = uq;
          next_hi = ur;
        end
      end
      MTHI: next_hi = src_a;
      MTLO: next_lo = src_a;
`ifdef MDU_MADD_EN
      MADD:  {next_hi, next_lo} = {hi, lo} + prod_s;
      MADDU: {next_hi, next_lo} = {hi, lo} + prod_u;
      MSUB:  {next_hi, next_lo} = {hi, lo} - prod_s;
      MSUBU: {next_hi, next_lo} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: pipeline MDU with HI/LO registers and a fixed-latency
// IDLE/BUSY sequencer. The result is computed at start and held until the
// countdown expires, then committed to HI/LO in one edge.
// Handshake: start is a one-cycle request accepted only in IDLE; busy is high
// exactly while a multiply/divide is in flight and starts during busy are dropped.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;

  mdu_calc u_calc (
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi      (hi_q),
    .lo      (lo_q),
    .next_hi (calc_hi),
    .next_lo (calc_lo)
  );

  // Next-state: accept ops in IDLE, count down in BUSY, commit when count hits 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_is_mul(op)) begin
            state_d  = ST_BUSY;
            cnt_d    = CNT_W'(MULT_CYCLES);
            res_hi_d = calc_hi;
            res_lo_d = calc_lo;
          end else if (op_is_div(op)) begin
            state_d  = ST_BUSY;
            cnt_d    = CNT_W'(DIV_CYCLES);
            res_hi_d = calc_hi;
            res_lo_d = calc_lo;
          end else if (op_is_move(op)) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
      end
    endcase
  end

  // State and register update; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with a queue-based
// scoreboard. Each entry holds the expected busy length, the HI/LO values
// that must hold during BUSY, and the final HI/LO (or an immediate snapshot).
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int EW = 137;  // {len[7:0], busy, hold_hi, hold_lo, hi, lo}

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            snap_req = 1'b0;

  function automatic logic [EW-1:0] mk(input logic [7:0] len, input logic b,
                                       input logic [31:0] hh, input logic [31:0] hl,
                                       input logic [31:0] eh, input logic [31:0] el);
    return {len, b, hh, hl, eh, el};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on busy fall or snapshot.
  logic          prev_busy = 1'b0;
  int            run_len   = 0;
  bit            hold_bad  = 1'b0;
  logic [EW-1:0] ent;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      run_len++;
      if (exp_q.size() > 0) begin
        ent = exp_q[0];
        if (hi !== ent[127:96] || lo !== ent[95:64]) hold_bad = 1'b1;
      end
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_busy: busy ran %0d cycles, required 0", run_len);
      end else begin
        ent = exp_q.pop_front();
        check("busy_len", 32'(run_len), {24'd0, ent[136:129]});
        check("hold_during_busy", {31'd0, hold_bad}, 32'd0);
        check("commit_hi", hi, ent[63:32]);
        check("commit_lo", lo, ent[31:0]);
      end
      run_len  = 0;
      hold_bad = 1'b0;
    end
    if (snap_req) begin
      snap_req = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL snap_queue: got empty queue, required an entry");
      end else begin
        ent = exp_q.pop_front();
        check("snap_busy", {31'd0, busy}, {31'd0, ent[128]});
        check("snap_hi", hi, ent[63:32]);
        check("snap_lo", lo, ent[31:0]);
      end
    end
    prev_busy = (busy === 1'b1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = NONE;
    src_a = 32'd0;
    src_b = 32'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (busy === 1'b1) begin
      n_checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", k);
    end
    tick();
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] len, input logic [31:0] hh, input logic [31:0] hl,
                        input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back(mk(len, 1'b1, hh, hl, eh, el));
    issue(o, a, b);
    wait_idle();
  endtask

  task automatic snap_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back(mk(8'd0, 1'b0, 32'd0, 32'd0, eh, el));
    issue(o, a, b);
    snap_req = 1'b1;
    tick();
  endtask

  initial begin
    // Reset held with a start present: the MTHI must be dropped.
    reset = 1'b1;
    start = 1'b1;
    op    = MTHI;
    src_a = 32'h0000_DEAD;
    src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    op    = NONE;
    src_a = 32'd0;
    exp_q.push_back(mk(8'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0));
    snap_req = 1'b1;
    tick();

    // Arithmetic vectors: len, hold_hi, hold_lo, hi, lo
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,         8'd5,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2,         8'd5,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         8'd10, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 8'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
    run_op(DIVU,  32'd100,       32'd7,         8'd10, 32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_000E);
    run_op(DIV,   32'd7,         32'hFFFF_FFFE, 8'd10, 32'h0000_0002, 32'h0000_000E, 32'h0000_0001, 32'hFFFF_FFFD);

    // Moves write immediately with busy low
    snap_op(MTHI, 32'h11, 32'd0, 32'h11, 32'hFFFF_FFFD);
    snap_op(MTLO, 32'h22, 32'd0, 32'h11, 32'h22);

    // Divide by zero: full latency, HI/LO unchanged; starts during BUSY ignored
    exp_q.push_back(mk(8'd10, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22));
    issue(DIVU, 32'd5, 32'd0);
    tick();
    issue(MULT, 32'd3, 32'd3);
    issue(MTHI, 32'h99, 32'd0);
    wait_idle();

    // Reset on the third busy cycle of a MULT: result discarded
    exp_q.push_back(mk(8'd3, 1'b1, 32'h11, 32'h22, 32'h0, 32'h0));
    issue(MULT, 32'd3, 32'd4);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    snap_op(NONE, 32'd0, 32'd0, 32'h0, 32'h0);

    // Recovery after reset
    run_op(MULTU, 32'h0001_0000, 32'h0001_0000, 8'd5, 32'h0, 32'h0, 32'h1, 32'h0);

    // Undefined codes have no effect
    snap_op(MTHI, 32'h0, 32'd0, 32'h0, 32'h0);
    snap_op(MTLO, 32'h5, 32'd0, 32'h0, 32'h5);
    snap_op(4'd11, 32'd9, 32'd9, 32'h0, 32'h5);
    snap_op(4'd15, 32'd9, 32'd9, 32'h0, 32'h5);

    // Multiply-accumulate
`ifdef MDU_MADD_EN
    run_op(MADD, 32'd2, 32'd3, 8'd5, 32'h0, 32'h5, 32'h0, 32'd11);
`else
    snap_op(MADD, 32'd2, 32'd3, 32'h0, 32'h5);
    repeat (6) tick();
`endif

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
